// File: rtl/regression_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : regression_seq_if
// Description : Handshake and operand bundle for regression_seq.
//               The master side is the feature/coefficient source together
//               with the result consumer. The slave side is the controller.
//               Source side : start/in_ready, clear, c0, cin, coef, feat.
//               Result side : y, y_valid/y_ready, ovf, busy.
// Revision    : 1.0  initial release
// ============================================================================
interface regression_seq_if #(
    parameter int N_FEAT = 3,
    parameter int FW     = 16,
    parameter int AW     = 32
);
    logic                   start;
    logic                   in_ready;
    logic                   clear;
    logic [AW-1:0]          c0;
    logic                   cin;
    logic [N_FEAT*FW-1:0]   coef;
    logic [N_FEAT*FW-1:0]   feat;
    logic [AW-1:0]          y;
    logic                   y_valid;
    logic                   y_ready;
    logic                   ovf;
    logic                   busy;

    modport master (
        output start, clear, c0, cin, coef, feat, y_ready,
        input  in_ready, y, y_valid, ovf, busy
    );

    modport slave (
        input  start, clear, c0, cin, coef, feat, y_ready,
        output in_ready, y, y_valid, ovf, busy
    );
endinterface
`default_nettype wire

// File: rtl/regression_seq.sv
`default_nettype none
// ============================================================================
// Module      : regression_seq
// Description : Time-multiplexed linear regression y = c0 + cin + sum(c*f).
//               The block has one shared FWxFW multiplier and one AW-bit
//               adder, and it performs one MAC per clock.
//               Ports:
//                 clk   - rising-edge clock
//                 rst_n - asynchronous active-low reset
//                 bus   - regression_seq_if.slave (operand source handshake,
//                         result handshake, clear, ovf, busy)
// Revision    : 1.0  initial release
// ============================================================================
module regression_seq #(
    parameter int N_FEAT = 3,
    parameter int FW     = 16,
    parameter int AW     = 32
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    regression_seq_if.slave    bus
);

    localparam int                IDXW     = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam logic [IDXW-1:0]   LAST_IDX = IDXW'(N_FEAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          acc_q, acc_d;
    logic [IDXW-1:0]        idx_q, idx_d;
    logic [N_FEAT*FW-1:0]   coef_q, coef_d;
    logic [N_FEAT*FW-1:0]   feat_q, feat_d;
    logic                   ovfr_q, ovfr_d;
    logic [AW-1:0]          y_q, y_d;
    logic                   ovf_q, ovf_d;
    logic                   yvalid_q, yvalid_d;

    logic [FW-1:0]          w_c;
    logic [FW-1:0]          w_f;
    logic [2*FW-1:0]        w_mul;
    logic [AW-1:0]          w_prod;
    logic [AW-1:0]          w_add_a;
    logic [AW-1:0]          w_add_b;
    logic [AW:0]            w_sum;

    // Operand select for the current MAC step.
    always_comb begin
        w_c = '0;
        w_f = '0;
        for (int i = 0; i < N_FEAT; i++) begin
            if (idx_q == IDXW'(i)) begin
                w_c = coef_q[i*FW +: FW];
                w_f = feat_q[i*FW +: FW];
            end
        end
    end

    assign w_mul  = {{FW{1'b0}}, w_c} * {{FW{1'b0}}, w_f};
    assign w_prod = AW'(w_mul);

    // The single adder does double duty. In IDLE it forms c0 + cin for the
    // accept edge. Otherwise it forms acc + product. Bit AW is the carry-out.
    always_comb begin
        if (state_q == S_IDLE) begin
            w_add_a = bus.c0;
            w_add_b = AW'(bus.cin);
        end else begin
            w_add_a = acc_q;
            w_add_b = w_prod;
        end
    end

    assign w_sum = {1'b0, w_add_a} + {1'b0, w_add_b};

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        coef_d   = coef_q;
        feat_d   = feat_q;
        ovfr_d   = ovfr_q;
        y_d      = y_q;
        ovf_d    = ovf_q;
        yvalid_d = yvalid_q;

        if (bus.clear) begin
            // Abort wins over everything. The last delivered y/ovf stay visible.
            state_d  = S_IDLE;
            yvalid_d = 1'b0;
            acc_d    = '0;
            idx_d    = '0;
            ovfr_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        coef_d  = bus.coef;
                        feat_d  = bus.feat;
                        acc_d   = w_sum[AW-1:0];
                        ovfr_d  = w_sum[AW];
                        idx_d   = '0;
                        state_d = S_MAC;
                    end
                end
                S_MAC: begin
                    acc_d  = w_sum[AW-1:0];
                    ovfr_d = ovfr_q | w_sum[AW];
                    if (idx_q == LAST_IDX) begin
                        idx_d    = '0;
                        y_d      = w_sum[AW-1:0];
                        ovf_d    = ovfr_q | w_sum[AW];
                        yvalid_d = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        idx_d = idx_q + IDXW'(1);
                    end
                end
                S_DONE: begin
                    if (bus.y_ready) begin
                        yvalid_d = 1'b0;
                        state_d  = S_IDLE;
                    end
                end
                default: begin
                    state_d  = S_IDLE;
                    yvalid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            idx_q    <= '0;
            coef_q   <= '0;
            feat_q   <= '0;
            ovfr_q   <= 1'b0;
            y_q      <= '0;
            ovf_q    <= 1'b0;
            yvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            coef_q   <= coef_d;
            feat_q   <= feat_d;
            ovfr_q   <= ovfr_d;
            y_q      <= y_d;
            ovf_q    <= ovf_d;
            yvalid_q <= yvalid_d;
        end
    end

    assign bus.in_ready = (state_q == S_IDLE);
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.y        = y_q;
    assign bus.ovf      = ovf_q;
    assign bus.y_valid  = yvalid_q;

endmodule
`default_nettype wire
